// File: rtl/cpu_core_p_if.sv
// cpu_core_p_if: RAM port, stall, status and interrupt signals between cpu_core_p and its environment.
interface cpu_core_p_if #(
    parameter int unsigned AW = 16
);
    logic          stall;
    logic [31:0]   q;
    logic [31:0]   data;
    logic [AW-1:0] address;
    logic          wren;
    logic [7:0]    status;
    logic          irq;
    logic [7:0]    irqn;

    modport master (
        input  stall, q, irq, irqn,
        output data, address, wren, status
    );

    modport slave (
        output stall, q, irq, irqn,
        input  data, address, wren, status
    );
endinterface

// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multicycle 32-bit core on a single-port synchronous RAM.
// Define CPU_IRQ_EN to build vectored interrupts (EI/DI/RETI, epc, ie); otherwise 15..17 are illegal.
module cpu_core_p #(
    parameter int unsigned AW       = 16,
    parameter int unsigned NREG     = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] VEC_BASE = 32'h0000_0010
) (
    input logic          clk,
    input logic          nreset,
    cpu_core_p_if.master bus
);
    localparam int unsigned RW = $clog2(NREG);

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LOAD     = 8'h01;
    localparam logic [7:0] OP_STORE    = 8'h02;
    localparam logic [7:0] OP_LOADI    = 8'h03;
    localparam logic [7:0] OP_STORI    = 8'h04;
    localparam logic [7:0] OP_LOADLI   = 8'h05;
    localparam logic [7:0] OP_LOADHI   = 8'h06;
    localparam logic [7:0] OP_LOADLISE = 8'h07;
    localparam logic [7:0] OP_JUMPZ    = 8'h08;
    localparam logic [7:0] OP_JUMPNZ   = 8'h09;
    localparam logic [7:0] OP_JUMPLT   = 8'h0A;
    localparam logic [7:0] OP_JUMPGTE  = 8'h0B;
    localparam logic [7:0] OP_MOV      = 8'h0C;
    localparam logic [7:0] OP_AND      = 8'h0D;
    localparam logic [7:0] OP_OR       = 8'h0E;
    localparam logic [7:0] OP_XOR      = 8'h0F;
    localparam logic [7:0] OP_ADD      = 8'h10;
    localparam logic [7:0] OP_SUB      = 8'h11;
    localparam logic [7:0] OP_MUL      = 8'h12;
`ifdef CPU_IRQ_EN
    localparam logic [7:0] OP_RETI     = 8'h15;
    localparam logic [7:0] OP_EI       = 8'h16;
    localparam logic [7:0] OP_DI       = 8'h17;
`endif

    localparam logic [7:0] ST_RESET = 8'hA0;
    localparam logic [7:0] ST_RUN   = 8'h00;
    localparam logic [7:0] ST_ISR   = 8'h01;
    localparam logic [7:0] ST_HALT  = 8'hE0;

    typedef enum logic [2:0] {F_WAIT, EXEC, M_WAIT, M_DONE, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [31:0]   regs [NREG];
    logic          mem_load;
    logic [RW-1:0] mem_rd;

    logic [7:0]    op;
    logic [RW-1:0] ra, rb, rc, rc_hi, load_rd;
    logic [31:0]   va, vb, vc, alu, store_val;
    logic [63:0]   product;
    logic [AW-1:0] pc_inc, pc_br, npc, mem_addr;
    logic          illegal, is_mem, is_store;

`ifdef CPU_IRQ_EN
    logic          ie;
    logic [AW-1:0] epc;
    logic          irq_take;
    logic [AW-1:0] vec;
    logic          unused_bits;
    assign unused_bits = ^bus.q[23:16];
`else
    logic          unused_bits;
    assign unused_bits = ^{bus.q[23:16], bus.irq, bus.irqn};
`endif

    // Decode of the instruction word presented on q during EXEC
    always_comb begin
        op        = bus.q[31:24];
        ra        = bus.q[16 +: RW];
        rb        = bus.q[8 +: RW];
        rc        = bus.q[0 +: RW];
        rc_hi     = rc + RW'(1);
        va        = regs[ra];
        vb        = regs[rb];
        vc        = regs[rc];
        product   = 64'(va) * 64'(vb);
        pc_inc    = pc + AW'(1);
        pc_br     = pc + AW'({{16{bus.q[15]}}, bus.q[15:0]});
        npc       = pc_inc;
        alu       = '0;
        illegal   = 1'b0;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        mem_addr  = AW'(va + vb);
        store_val = vc;
        load_rd   = rc;
        case (op)
            OP_NOP, OP_LOADLI, OP_LOADHI, OP_LOADLISE, OP_MOV, OP_MUL: ;
            OP_AND:    alu = va & vb;
            OP_OR:     alu = va | vb;
            OP_XOR:    alu = va ^ vb;
            OP_ADD:    alu = va + vb;
            OP_SUB:    alu = va - vb;
            OP_LOAD:   is_mem = 1'b1;
            OP_STORE: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_LOADI: begin
                is_mem   = 1'b1;
                mem_addr = AW'(bus.q[15:0]);
                load_rd  = ra;
            end
            OP_STORI: begin
                is_mem    = 1'b1;
                is_store  = 1'b1;
                mem_addr  = AW'(bus.q[15:0]);
                store_val = va;
            end
            OP_JUMPZ:   if (va == 32'h0) npc = pc_br;
            OP_JUMPNZ:  if (va != 32'h0) npc = pc_br;
            OP_JUMPLT:  if (va[31])      npc = pc_br;
            OP_JUMPGTE: if (!va[31])     npc = pc_br;
`ifdef CPU_IRQ_EN
            OP_RETI:    npc = epc;
            OP_EI, OP_DI: ;
`endif
            default:    illegal = 1'b1;
        endcase
`ifdef CPU_IRQ_EN
        irq_take = bus.irq && ie;
        vec      = AW'(VEC_BASE + 32'(bus.irqn));
`endif
    end

    // Sequencer, register file and RAM port; stall freezes everything but reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= F_WAIT;
            pc          <= RESET_PC[AW-1:0];
            bus.address <= RESET_PC[AW-1:0];
            bus.wren    <= 1'b0;
            bus.data    <= 32'h0;
            bus.status  <= ST_RESET;
            mem_load    <= 1'b0;
            mem_rd      <= '0;
            for (int i = 0; i < int'(NREG); i++) regs[i] <= 32'h0;
`ifdef CPU_IRQ_EN
            ie          <= 1'b0;
            epc         <= '0;
`endif
        end else if (!bus.stall) begin
            case (state)
                F_WAIT: begin
                    state <= EXEC;
                    if (bus.status == ST_RESET) bus.status <= ST_RUN;
                end
                EXEC: begin
                    if (illegal) begin
                        state      <= HALT;
                        bus.status <= ST_HALT;
                    end else if (is_mem) begin
                        state       <= M_WAIT;
                        pc          <= pc_inc;
                        bus.address <= mem_addr;
                        bus.wren    <= is_store;
                        if (is_store) bus.data <= store_val;
                        mem_load    <= !is_store;
                        mem_rd      <= load_rd;
                    end else begin
                        state       <= F_WAIT;
                        pc          <= npc;
                        bus.address <= npc;
                        case (op)
                            OP_LOADLI:   regs[ra][15:0]  <= bus.q[15:0];
                            OP_LOADHI:   regs[ra][31:16] <= bus.q[15:0];
                            OP_LOADLISE: regs[ra] <= {{16{bus.q[15]}}, bus.q[15:0]};
                            OP_MOV:      regs[rb] <= va;
                            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: regs[rc] <= alu;
                            OP_MUL: begin
                                // high word written last so it wins an index collision
                                regs[rc]    <= product[31:0];
                                regs[rc_hi] <= product[63:32];
                            end
                            default: ;
                        endcase
`ifdef CPU_IRQ_EN
                        if (op == OP_EI) ie <= 1'b1;
                        if (op == OP_DI) ie <= 1'b0;
                        if (op == OP_RETI) begin
                            ie         <= 1'b1;
                            bus.status <= ST_RUN;
                        end
                        if (irq_take) begin
                            epc         <= npc;
                            ie          <= 1'b0;
                            pc          <= vec;
                            bus.address <= vec;
                            bus.status  <= ST_ISR;
                        end
`endif
                    end
                end
                M_WAIT: begin
                    bus.wren <= 1'b0;
                    state    <= M_DONE;
                end
                M_DONE: begin
                    if (mem_load) regs[mem_rd] <= bus.q;
                    bus.address <= pc;
                    state       <= F_WAIT;
`ifdef CPU_IRQ_EN
                    if (irq_take) begin
                        epc         <= pc;
                        ie          <= 1'b0;
                        pc          <= vec;
                        bus.address <= vec;
                        bus.status  <= ST_ISR;
                    end
`endif
                end
                HALT: ;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed programs with hand-computed results for cpu_core_p (AW=16, NREG=16).
module tb_cpu_core_p;
    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    logic nreset;
    logic load_img;
    logic [31:0] img [256];
    logic [31:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    cpu_core_p_if #(.AW(AW)) bus ();

    cpu_core_p #(
        .AW(AW), .NREG(16), .RESET_PC(32'h0), .VEC_BASE(32'h10)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: q shows mem[address] one cycle later
    always @(posedge clk) begin
        bus.q <= mem[bus.address[7:0]];
        if (load_img) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.wren) begin
            mem[bus.address[7:0]] <= bus.data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    // Reset with the current image loaded; returns at the start of cycle 1 after release
    task automatic start();
        bus.stall = 1'b0;
        bus.irq   = 1'b0;
        bus.irqn  = 8'h0;
        nreset    = 1'b0;
        load_img  = 1'b1;
        step(2);
        load_img  = 1'b0;
        check_eq("rst_status", 32'(bus.status), 32'hA0);
        check_eq("rst_address", 32'(bus.address), 32'h0);
        check_eq("rst_wren", 32'(bus.wren), 32'h0);
        nreset = 1'b1;
    endtask

    int wr_count;
    logic [31:0] wr_addr, wr_data, addr_c14;

    initial begin
        nreset   = 1'b0;
        load_img = 1'b0;

        // LOADLI r1,5; LOADLI r2,7; ADD r1,r2,r3
        clear_img();
        img[0] = 32'h0501_0005;
        img[1] = 32'h0502_0007;
        img[2] = 32'h1001_0203;
        start();
        step(2);
        check_eq("t1_addr_c3", 32'(bus.address), 32'h1);
        step(2);
        check_eq("t1_addr_c5", 32'(bus.address), 32'h2);
        step(2);
        check_eq("t1_r3", dut.regs[3], 32'd12);
        check_eq("t1_addr_c7", 32'(bus.address), 32'h3);
        check_eq("t1_status", 32'(bus.status), 32'h00);

        // LOADLISE r1,FFFF; JUMPLT r1,+4; (pc 5) JUMPGTE r1,+16 not taken
        clear_img();
        img[0] = 32'h0701_FFFF;
        img[1] = 32'h0A01_0004;
        img[5] = 32'h0B01_0010;
        start();
        step(4);
        check_eq("t2_r1", dut.regs[1], 32'hFFFF_FFFF);
        check_eq("t2_jumplt_addr", 32'(bus.address), 32'h5);
        step(2);
        check_eq("t2_jumpgte_addr", 32'(bus.address), 32'h6);
        check_eq("t2_pc", 32'(dut.pc), 32'h6);

        // SUB, XOR, MOV, JUMPZ forward, JUMPNZ backward
        clear_img();
        img[0]     = 32'h0504_00F0;
        img[1]     = 32'h0505_0F3C;
        img[2]     = 32'h1104_0506;
        img[3]     = 32'h0F04_0507;
        img[4]     = 32'h0C04_0800;
        img[5]     = 32'h0809_0010;
        img[8'h15] = 32'h0904_FFFE;
        start();
        step(12);
        check_eq("t3_jumpz_addr", 32'(bus.address), 32'h15);
        step(2);
        check_eq("t3_jumpnz_addr", 32'(bus.address), 32'h13);
        check_eq("t3_sub", dut.regs[6], 32'hFFFF_F1B4);
        check_eq("t3_xor", dut.regs[7], 32'h0000_0FCC);
        check_eq("t3_mov", dut.regs[8], 32'h0000_00F0);

        // LOADLI/LOADHI r1=DEADBEEF; STORI r1,0x40; LOADI r2,0x40 with a stall in the load's M_WAIT
        clear_img();
        img[0] = 32'h0501_BEEF;
        img[1] = 32'h0601_DEAD;
        img[2] = 32'h0401_0040;
        img[3] = 32'h0302_0040;
        start();
        wr_count = 0;
        wr_addr  = 32'h0;
        wr_data  = 32'h0;
        addr_c14 = 32'h0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (bus.wren) begin
                wr_count++;
                wr_addr = 32'(bus.address);
                wr_data = bus.data;
            end
            if (cyc == 14) addr_c14 = 32'(bus.address);
            bus.stall = (cyc == 11);
            step(1);
        end
        bus.stall = 1'b0;
        check_eq("t4_wren_cycles", 32'(wr_count), 32'd1);
        check_eq("t4_wr_addr", wr_addr, 32'h40);
        check_eq("t4_wr_data", wr_data, 32'hDEAD_BEEF);
        check_eq("t4_mem40", mem[8'h40], 32'hDEAD_BEEF);
        check_eq("t4_r2", dut.regs[2], 32'hDEAD_BEEF);
        check_eq("t4_fetch_after_load", addr_c14, 32'h4);

        // MUL r1=FFFFFFFF * r2=2 into r15 and r0 (wrap)
        clear_img();
        img[0] = 32'h0701_FFFF;
        img[1] = 32'h0502_0002;
        img[2] = 32'h1201_020F;
        start();
        step(6);
        check_eq("t5_mul_lo", dut.regs[15], 32'hFFFF_FFFE);
        check_eq("t5_mul_hi", dut.regs[0], 32'h0000_0001);

        // Illegal opcode 0x3C at pc 2 halts; one reset edge recovers
        clear_img();
        img[2] = 32'h3C00_0000;
        start();
        step(6);
        check_eq("t6_halt_status", 32'(bus.status), 32'hE0);
        check_eq("t6_halt_wren", 32'(bus.wren), 32'h0);
        check_eq("t6_halt_addr", 32'(bus.address), 32'h2);
        step(4);
        check_eq("t6_halt_addr_hold", 32'(bus.address), 32'h2);
        check_eq("t6_halt_status_hold", 32'(bus.status), 32'hE0);
        nreset = 1'b0;
        step(1);
        check_eq("t6_reset_status", 32'(bus.status), 32'hA0);
        check_eq("t6_reset_pc", 32'(dut.pc), 32'h0);
        check_eq("t6_reset_addr", 32'(bus.address), 32'h0);
        nreset = 1'b1;

`ifdef CPU_IRQ_EN
        // EI; irq 3 during ADD at pc 8; ISR NOP then RETI at 0x14
        clear_img();
        img[0]     = 32'h1600_0000;
        img[1]     = 32'h0501_0005;
        img[2]     = 32'h0502_0007;
        img[8]     = 32'h1001_0203;
        img[8'h14] = 32'h1500_0000;
        start();
        step(17);
        bus.irq  = 1'b1;
        bus.irqn = 8'd3;
        step(1);
        check_eq("t7_add_result", dut.regs[3], 32'd12);
        check_eq("t7_vector_addr", 32'(bus.address), 32'h13);
        check_eq("t7_epc", 32'(dut.epc), 32'h9);
        check_eq("t7_status_isr", 32'(bus.status), 32'h01);
        check_eq("t7_ie_cleared", 32'(dut.ie), 32'h0);
        step(2);
        check_eq("t7_no_nested_irq", 32'(bus.address), 32'h14);
        step(1);
        bus.irq = 1'b0;
        step(1);
        check_eq("t7_reti_addr", 32'(bus.address), 32'h9);
        check_eq("t7_reti_ie", 32'(dut.ie), 32'h1);
        check_eq("t7_reti_status", 32'(bus.status), 32'h00);
`else
        // Without interrupt support EI (0x16) is illegal
        clear_img();
        img[0] = 32'h1600_0000;
        start();
        bus.irq  = 1'b1;
        bus.irqn = 8'd3;
        step(2);
        check_eq("t7_ei_illegal_status", 32'(bus.status), 32'hE0);
        check_eq("t7_ei_illegal_addr", 32'(bus.address), 32'h0);
        bus.irq = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
